// File: rtl/seq_detea.sv
// Moore detector for serial pattern 1-0-0-0-1 (first bit first), overlapping hits count.
// Latency: dout rises on the edge that samples the final '1' and holds exactly one cycle.
// Backpressure: none; one bit is consumed every rising clk edge.
//
// Ports:
//   clk   in   1  rising-edge clock
//   clr   in   1  asynchronous active-high reset, forces S0
//   din   in   1  serial data bit
//   dout  out  1  detect flag, high only in S5
//   stat  out  3  current state code (S0=0 .. S5=5)
module seq_detea (
  input  logic       clk,
  input  logic       clr,
  input  logic       din,
  output logic       dout,
  output logic [2:0] stat
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle / no prefix
    S1 = 3'd1,  // "1"
    S2 = 3'd2,  // "10"
    S3 = 3'd3,  // "100"
    S4 = 3'd4,  // "1000"
    S5 = 3'd5   // "10001" detected
  } state_t;

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = S0;
    case (state)
      S0:      state_nxt = din ? S1 : S0;
      S1:      state_nxt = din ? S1 : S2;
      S2:      state_nxt = din ? S1 : S3;
      S3:      state_nxt = din ? S1 : S4;
      S4:      state_nxt = din ? S5 : S0;
      // The trailing '1' of a hit is also the leading '1' of the next
      // candidate, so a following '0' already means "10".
      S5:      state_nxt = din ? S1 : S2;
      // Codes 6 and 7 are unreachable in normal operation; recover to idle.
      default: state_nxt = S0;
    endcase
  end

  // Outputs decode the state register only: no din-to-dout path.
  assign stat = state;
  assign dout = (state == S5);

endmodule

// File: tb/tb_seq_detea.sv
module tb_seq_detea;

  logic       clk;
  logic       clr;
  logic       din;
  logic       dout;
  logic [2:0] stat;

  int checks;
  int errors;
  int sb_idx;

  typedef struct packed {
    logic [2:0] stat;
    logic       dout;
  } exp_t;

  exp_t exp_q[$];

  seq_detea dut (
    .clk  (clk),
    .clr  (clr),
    .din  (din),
    .dout (dout),
    .stat (stat)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] a_stat, input logic a_dout,
                     input logic [2:0] e_stat, input logic e_dout);
    checks++;
    if (a_stat !== e_stat || a_dout !== e_dout) begin
      errors++;
      $display("FAIL %s @%0t: got stat=%0d dout=%b, want stat=%0d dout=%b",
               name, $time, a_stat, a_dout, e_stat, e_dout);
    end
  endtask

  // Drive one bit mid-cycle and record the state/flag expected after the next rising edge.
  task automatic step(input logic b, input logic [2:0] e_stat, input logic e_dout);
    exp_t e;
    @(negedge clk);
    din = b;
    e.stat = e_stat;
    e.dout = e_dout;
    exp_q.push_back(e);
  endtask

  // Monitor: after every rising edge, compare the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #5;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        sb_idx++;
        chk($sformatf("sb[%0d]", sb_idx), stat, dout, e.stat, e.dout);
      end
    end
  end

  initial begin
    int wait_cyc;
    checks = 0;
    errors = 0;
    sb_idx = 0;

    // 1: reset held with din toggling across rising edges
    clr = 1'b1;
    din = 1'b0;
    #5;
    for (int i = 0; i < 5; i++) begin
      din = ~din;
      #9;
      chk($sformatf("reset_hold%0d", i), stat, dout, 3'd0, 1'b0);
      #1;
    end
    @(negedge clk);
    chk("reset_before_release", stat, dout, 3'd0, 1'b0);
    din = 1'b0;
    clr = 1'b0;

    // 2: all-zero stream
    for (int i = 0; i < 10; i++) step(1'b0, 3'd0, 1'b0);

    // 3: single hit, then drain back to idle through S5 -> S2
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b1);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b0, 3'd0, 1'b0);

    // 4: overlapping hits 100010001, then S5 -> S1 on a '1'
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b1);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b1);
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b0, 3'd0, 1'b0);

    // 5: near miss 100001
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    step(1'b1, 3'd1, 1'b0);

    // 6: mid-run reset discards the "100" prefix
    step(1'b1, 3'd1, 1'b0);
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("midreset_immediate", stat, dout, 3'd0, 1'b0);
    din = 1'b1;
    @(posedge clk);
    #5;
    chk("midreset_edge_held", stat, dout, 3'd0, 1'b0);
    @(negedge clk);
    din = 1'b0;
    clr = 1'b0;
    step(1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd1, 1'b0);
    // detection still works after the reset
    step(1'b0, 3'd2, 1'b0);
    step(1'b0, 3'd3, 1'b0);
    step(1'b0, 3'd4, 1'b0);
    step(1'b1, 3'd5, 1'b1);
    step(1'b0, 3'd2, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #10;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
